// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core run sequencer.
// Pure declarations; no logic, no latency.
// Holds the FSM state encoding, the HALT opcode and the default widths.
package core_seq_pkg;

  localparam int PC_W_DEF    = 6;
  localparam int INSTR_W_DEF = 9;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int CYC_W_DEF   = 16;

  // All-ones opcode reserved as the program terminator
  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_MEMWAIT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
// Count and flag are registered; one-cycle update latency.
// No backpressure: counts whenever enabled, holds at all-ones and raises the flag.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         full,
  output logic         sat
);

  // Counter sits at its ceiling; the next enabled cycle overflows
  assign full = &count;

  // Clear wins over enable; an enabled cycle at the ceiling latches the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      if (full) begin
        sat <= 1'b1;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Run controller for the 9-bit core: PC/write-back gating, load stall, HALT, timeout.
// Enables and arbitration are combinational from state; done/timeout/count registered.
// Loads stall one cycle; the core always wins the data-memory port, the host waits.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CYC_W   = CYC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_read_req,
  input  logic               mem_write_req,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [DATA_W-1:0]  core_wdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               pc_en,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               reg_write_en,
  output logic               host_gnt,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycle_count
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [PC_W-1:0]   entry_pc;
  logic              is_halt;
  logic              in_run;
  logic              accept_start;
  logic              cyc_full;
  logic              core_act;
  logic              core_we;

  assign is_halt      = (instruction == INSTR_W'(HALT_INSTR));
  assign in_run       = (state == ST_RUN);
  assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign busy         = (state == ST_INIT) || in_run || (state == ST_MEMWAIT);

  // PC entry point is captured when a start is accepted so INIT loads a stable value
  assign pc_load_val = entry_pc;

  // State register plus the registered done flag, which mirrors entry into DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      entry_pc <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == ST_DONE);
      if (accept_start) begin
        entry_pc <= start_pc;
      end
    end
  end

  // Next state and PC/write-back gating; timeout beats HALT, HALT beats a load
  always_comb begin
    state_nxt    = state;
    pc_en        = 1'b0;
    pc_load      = 1'b0;
    reg_write_en = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        pc_load   = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cyc_full) begin
          state_nxt = ST_DONE;
        end else if (is_halt) begin
          state_nxt = ST_DONE;
        end else if (mem_read_req) begin
          state_nxt = ST_MEMWAIT;
        end else begin
          pc_en        = 1'b1;
          reg_write_en = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (cyc_full) begin
          state_nxt = ST_DONE;
        end else begin
          pc_en        = 1'b1;
          reg_write_en = 1'b1;
          state_nxt    = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Cycle counter is zeroed on the edge that enters INIT so INIT itself reads zero
  sat_counter #(
    .W(CYC_W)
  ) u_cycles (
    .clk   (clk),
    .rst_n (reset),
    .clr   (accept_start),
    .en    (busy),
    .count (cycle_count),
    .full  (cyc_full),
    .sat   (timeout)
  );

  // Data-memory port: the core owns it on any live access, otherwise the host may take it
  always_comb begin
    core_act = (in_run && (mem_read_req || mem_write_req) && !is_halt) ||
               (state == ST_MEMWAIT);
    core_we  = in_run && mem_write_req && !is_halt;
    host_gnt = host_req && !core_act;
    if (host_gnt) begin
      dmem_addr  = host_addr;
      dmem_wdata = host_wdata;
      dmem_we    = host_we;
    end else begin
      dmem_addr  = core_addr;
      dmem_wdata = core_wdata;
      dmem_we    = core_we;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: table-driven cycles feed an expectation queue.
// A second instance with a 4-bit cycle counter exercises timeout and restart.
// Outputs sampled on the falling edge; inputs driven just after the rising edge.
module tb_core_sequencer;

  localparam logic [8:0] ALU  = 9'h0A3;
  localparam logic [8:0] HALT = 9'h1FF;

  typedef struct packed {
    logic        pe;
    logic        pl;
    logic [5:0]  plv;
    logic        rwe;
    logic        gnt;
    logic [7:0]  addr;
    logic        we;
    logic        busy;
    logic        done;
    logic        to;
    logic [15:0] cc;
  } obs_t;

  typedef struct packed {
    logic       start;
    logic       start_to;
    logic [5:0] spc;
    logic [8:0] ins;
    logic       rd;
    logic       wr;
    logic [7:0] caddr;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
  } stim_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       start_to;
  logic [5:0] start_pc;
  logic [8:0] instruction;
  logic       mem_read_req;
  logic       mem_write_req;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;

  logic        m_pc_en, m_pc_load, m_rwe, m_gnt, m_we, m_busy, m_done, m_to;
  logic [5:0]  m_plv;
  logic [7:0]  m_addr, m_wdata;
  logic [15:0] m_cc;

  logic        t_pc_en, t_pc_load, t_rwe, t_gnt, t_we, t_busy, t_done, t_to;
  logic [5:0]  t_plv;
  logic [7:0]  t_addr, t_wdata;
  logic [3:0]  t_cc;

  int   total;
  int   bad;
  obs_t exp_q[$];

  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .instruction(instruction), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .core_addr(core_addr), .core_wdata(core_wdata), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .pc_en(m_pc_en), .pc_load(m_pc_load),
    .pc_load_val(m_plv), .reg_write_en(m_rwe), .host_gnt(m_gnt), .dmem_addr(m_addr),
    .dmem_wdata(m_wdata), .dmem_we(m_we), .busy(m_busy), .done(m_done), .timeout(m_to),
    .cycle_count(m_cc)
  );

  core_sequencer #(.CYC_W(4)) dut_to (
    .clk(clk), .reset(reset), .start(start_to), .start_pc(start_pc),
    .instruction(instruction), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .core_addr(core_addr), .core_wdata(core_wdata), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .pc_en(t_pc_en), .pc_load(t_pc_load),
    .pc_load_val(t_plv), .reg_write_en(t_rwe), .host_gnt(t_gnt), .dmem_addr(t_addr),
    .dmem_wdata(t_wdata), .dmem_we(t_we), .busy(t_busy), .done(t_done), .timeout(t_to),
    .cycle_count(t_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic pe, input logic pl, input logic [5:0] plv,
                              input logic rwe, input logic gnt, input logic [7:0] addr,
                              input logic we, input logic bsy, input logic dn,
                              input logic to, input logic [15:0] cc);
    obs_t o;
    o = '{pe: pe, pl: pl, plv: plv, rwe: rwe, gnt: gnt, addr: addr, we: we,
          busy: bsy, done: dn, to: to, cc: cc};
    return o;
  endfunction

  function automatic stim_t sm(input logic s, input logic s2, input logic [5:0] spc,
                               input logic [8:0] ins, input logic rd, input logic wr,
                               input logic [7:0] caddr, input logic hreq, input logic hwe,
                               input logic [7:0] haddr);
    stim_t r;
    r = '{start: s, start_to: s2, spc: spc, ins: ins, rd: rd, wr: wr, caddr: caddr,
          hreq: hreq, hwe: hwe, haddr: haddr};
    return r;
  endfunction

  function automatic obs_t obs_main();
    return mk(m_pc_en, m_pc_load, m_plv, m_rwe, m_gnt, m_addr, m_we, m_busy, m_done, m_to, m_cc);
  endfunction

  function automatic obs_t obs_to();
    return mk(t_pc_en, t_pc_load, t_plv, t_rwe, t_gnt, t_addr, t_we, t_busy, t_done, t_to,
              {12'h000, t_cc});
  endfunction

  task automatic apply(input stim_t s);
    start         = s.start;
    start_to      = s.start_to;
    start_pc      = s.spc;
    instruction   = s.ins;
    mem_read_req  = s.rd;
    mem_write_req = s.wr;
    core_addr     = s.caddr;
    host_req      = s.hreq;
    host_we       = s.hwe;
    host_addr     = s.haddr;
  endtask

  task automatic kick(input stim_t s);
    apply(s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    reset = 1'b0;
    apply(sm(0, 0, 6'd0, ALU, 0, 1, 8'h00, 1, 0, 8'h55));
    #3;
    exp_q.push_back(mk(0, 0, 6'd0, 0, 1, 8'h55, 0, 0, 0, 0, 16'd0));
    got = obs_main(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_main got=%h want=%h", got, want); end
    exp_q.push_back(mk(0, 0, 6'd0, 0, 1, 8'h55, 0, 0, 0, 0, 16'd0));
    got = obs_to(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_to got=%h want=%h", got, want); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_program();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    kick(sm(1, 0, 6'd5, ALU, 0, 0, 8'h00, 0, 0, 8'h00));
    sq.push_back(sm(0, 0, 6'd5, ALU, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(0, 1, 6'd5, 0, 0, 8'h00, 0, 1, 0, 0, 16'd0));
    for (int k = 1; k <= 3; k++) begin
      sq.push_back(sm(0, 0, 6'd5, ALU, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(1, 0, 6'd5, 1, 0, 8'h00, 0, 1, 0, 0, 16'(k)));
    end
    sq.push_back(sm(0, 0, 6'd5, HALT, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(0, 0, 6'd5, 0, 0, 8'h00, 0, 1, 0, 0, 16'd4));
    sq.push_back(sm(0, 0, 6'd5, ALU, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(0, 0, 6'd5, 0, 0, 8'h00, 0, 0, 1, 0, 16'd5));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); exp_q.push_back(eq[i]);
      @(negedge clk); got = obs_main(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL program c%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    kick(sm(1, 0, 6'd12, ALU, 0, 0, 8'h12, 0, 0, 8'h40));
    sq.push_back(sm(0, 0, 6'd12, ALU, 0, 0, 8'h12, 1, 0, 8'h40));  eq.push_back(mk(0, 1, 6'd12, 0, 1, 8'h40, 0, 1, 0, 0, 16'd0));
    sq.push_back(sm(0, 0, 6'd12, ALU, 1, 0, 8'h12, 1, 0, 8'h40));  eq.push_back(mk(0, 0, 6'd12, 0, 0, 8'h12, 0, 1, 0, 0, 16'd1));
    sq.push_back(sm(0, 0, 6'd12, ALU, 1, 0, 8'h12, 1, 0, 8'h40));  eq.push_back(mk(1, 0, 6'd12, 1, 0, 8'h12, 0, 1, 0, 0, 16'd2));
    sq.push_back(sm(0, 0, 6'd12, ALU, 0, 0, 8'h12, 1, 0, 8'h40));  eq.push_back(mk(1, 0, 6'd12, 1, 1, 8'h40, 0, 1, 0, 0, 16'd3));
    sq.push_back(sm(0, 0, 6'd12, HALT, 0, 0, 8'h12, 0, 0, 8'h40)); eq.push_back(mk(0, 0, 6'd12, 0, 0, 8'h12, 0, 1, 0, 0, 16'd4));
    sq.push_back(sm(0, 0, 6'd12, ALU, 0, 0, 8'h12, 0, 0, 8'h40));  eq.push_back(mk(0, 0, 6'd12, 0, 0, 8'h12, 0, 0, 1, 0, 16'd5));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); exp_q.push_back(eq[i]);
      @(negedge clk); got = obs_main(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL load c%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_arb();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    kick(sm(1, 0, 6'd7, ALU, 0, 0, 8'h20, 0, 0, 8'h30));
    sq.push_back(sm(0, 0, 6'd7, ALU, 0, 0, 8'h20, 0, 0, 8'h30));  eq.push_back(mk(0, 1, 6'd7, 0, 0, 8'h20, 0, 1, 0, 0, 16'd0));
    sq.push_back(sm(0, 0, 6'd7, ALU, 0, 1, 8'h20, 1, 1, 8'h30));  eq.push_back(mk(1, 0, 6'd7, 1, 0, 8'h20, 1, 1, 0, 0, 16'd1));
    sq.push_back(sm(0, 0, 6'd7, ALU, 0, 0, 8'h20, 1, 1, 8'h30));  eq.push_back(mk(1, 0, 6'd7, 1, 1, 8'h30, 1, 1, 0, 0, 16'd2));
    sq.push_back(sm(0, 0, 6'd7, HALT, 0, 1, 8'h20, 0, 0, 8'h30)); eq.push_back(mk(0, 0, 6'd7, 0, 0, 8'h20, 0, 1, 0, 0, 16'd3));
    sq.push_back(sm(0, 0, 6'd7, ALU, 0, 0, 8'h20, 1, 1, 8'h30));  eq.push_back(mk(0, 0, 6'd7, 0, 1, 8'h30, 1, 0, 1, 0, 16'd4));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); exp_q.push_back(eq[i]);
      @(negedge clk); got = obs_main(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL store_arb c%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_ignored();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    kick(sm(1, 0, 6'd3, ALU, 0, 0, 8'h00, 0, 0, 8'h00));
    sq.push_back(sm(0, 0, 6'd3, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 1, 6'd3, 0, 0, 8'h00, 0, 1, 0, 0, 16'd0));
    sq.push_back(sm(1, 0, 6'd9, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(1, 0, 6'd3, 1, 0, 8'h00, 0, 1, 0, 0, 16'd1));
    sq.push_back(sm(0, 0, 6'd9, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(1, 0, 6'd3, 1, 0, 8'h00, 0, 1, 0, 0, 16'd2));
    sq.push_back(sm(0, 0, 6'd9, HALT, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(0, 0, 6'd3, 0, 0, 8'h00, 0, 1, 0, 0, 16'd3));
    sq.push_back(sm(0, 0, 6'd9, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 0, 6'd3, 0, 0, 8'h00, 0, 0, 1, 0, 16'd4));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); exp_q.push_back(eq[i]);
      @(negedge clk); got = obs_main(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL start_ignored c%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    kick(sm(0, 1, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00));
    sq.push_back(sm(0, 0, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(0, 1, 6'd2, 0, 0, 8'h00, 0, 1, 0, 0, 16'd0));
    for (int k = 1; k <= 14; k++) begin
      sq.push_back(sm(0, 0, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(1, 0, 6'd2, 1, 0, 8'h00, 0, 1, 0, 0, 16'(k)));
    end
    sq.push_back(sm(0, 0, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 0, 6'd2, 0, 0, 8'h00, 0, 1, 0, 0, 16'd15));
    sq.push_back(sm(0, 0, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 0, 6'd2, 0, 0, 8'h00, 0, 0, 1, 1, 16'd15));
    sq.push_back(sm(0, 1, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 0, 6'd2, 0, 0, 8'h00, 0, 0, 1, 1, 16'd15));
    sq.push_back(sm(0, 0, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 1, 6'd2, 0, 0, 8'h00, 0, 1, 0, 0, 16'd0));
    sq.push_back(sm(0, 0, 6'd2, HALT, 0, 0, 8'h00, 0, 0, 8'h00)); eq.push_back(mk(0, 0, 6'd2, 0, 0, 8'h00, 0, 1, 0, 0, 16'd1));
    sq.push_back(sm(0, 0, 6'd2, ALU, 0, 0, 8'h00, 0, 0, 8'h00));  eq.push_back(mk(0, 0, 6'd2, 0, 0, 8'h00, 0, 0, 1, 0, 16'd2));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); exp_q.push_back(eq[i]);
      @(negedge clk); got = obs_to(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL timeout c%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    kick(sm(1, 0, 6'd4, ALU, 0, 0, 8'h20, 0, 0, 8'h55));
    sq.push_back(sm(0, 0, 6'd4, ALU, 0, 0, 8'h20, 0, 0, 8'h55)); eq.push_back(mk(0, 1, 6'd4, 0, 0, 8'h20, 0, 1, 0, 0, 16'd0));
    sq.push_back(sm(0, 0, 6'd4, ALU, 0, 1, 8'h20, 0, 0, 8'h55)); eq.push_back(mk(1, 0, 6'd4, 1, 0, 8'h20, 1, 1, 0, 0, 16'd1));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); exp_q.push_back(eq[i]);
      @(negedge clk); got = obs_main(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mid_reset_run c%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
    // Still mid-store in RUN; drop reset between edges with the host requesting a read
    apply(sm(0, 0, 6'd4, ALU, 0, 1, 8'h20, 1, 0, 8'h55));
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 6'd0, 0, 1, 8'h55, 0, 0, 0, 0, 16'd0));
    got = obs_main(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL mid_reset_held got=%h want=%h", got, want); end
    exp_q.push_back(mk(0, 0, 6'd0, 0, 1, 8'h55, 0, 0, 0, 0, 16'd0));
    got = obs_to(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL mid_reset_to got=%h want=%h", got, want); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(0, 0, 6'd0, 0, 1, 8'h55, 0, 0, 0, 0, 16'd0));
    @(negedge clk); got = obs_main(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL mid_reset_after got=%h want=%h", got, want); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    core_wdata = 8'hA5;
    host_wdata = 8'h5A;
    test_reset();
    test_program();
    test_load();
    test_store_arb();
    test_start_ignored();
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
